// File: rtl/sobel_col_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : sobel_col_feeder
//  Description : Reads a raster-order grayscale image from a single-port SRAM
//                and presents it as one vertical 3-pixel column per cycle
//                (rows r-2, r-1, r) with an enable qualifier for a Sobel stage.
//                Two IMG_W-deep line buffers are primed before columns stream.
//                Once streaming starts, enable stays high without gaps until
//                the last column has been shown.
//  Ports       : clk          - clock, all state on the rising edge
//                reset        - asynchronous active-high reset
//                start        - frame request, honoured in IDLE / DONE only
//                mem_rd_en    - SRAM read strobe
//                mem_addr     - SRAM read address (row*IMG_W + col)
//                mem_rd_data  - SRAM data, valid the cycle after mem_rd_en
//                pixel_out0   - column top pixel    (row r-2)
//                pixel_out1   - column middle pixel (row r-1)
//                pixel_out2   - column bottom pixel (row r)
//                enable       - pixel_out0..2 hold a valid column
//                done         - frame fully delivered (level)
//  Revision    : 1.0 - initial release
// ============================================================================
module sobel_col_feeder #(
    parameter int BIT_LENGTH = 5,
    parameter int IMG_W      = 16,
    parameter int IMG_H      = 16,
    parameter int ADDR_W     = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  mem_rd_en,
    output logic [ADDR_W-1:0]     mem_addr,
    input  logic [BIT_LENGTH-1:0] mem_rd_data,
    output logic [BIT_LENGTH-1:0] pixel_out0,
    output logic [BIT_LENGTH-1:0] pixel_out1,
    output logic [BIT_LENGTH-1:0] pixel_out2,
    output logic                  enable,
    output logic                  done
);

    // Last priming address, first streaming address, last frame address.
    localparam logic [ADDR_W-1:0] c_prime_last   = ADDR_W'(2*IMG_W - 1);
    localparam logic [ADDR_W-1:0] c_stream_first = ADDR_W'(2*IMG_W);
    localparam logic [ADDR_W-1:0] c_last_addr    = ADDR_W'(IMG_W*IMG_H - 1);
    localparam logic [ADDR_W-1:0] c_addr_one     = ADDR_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PRIME  = 2'd1,
        S_STREAM = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                state_q,    state_d;
    logic                  rd_en_q,    rd_en_d;
    logic [ADDR_W-1:0]     addr_q,     addr_d;
    // Read-return tracking: data for the read issued last cycle is on the bus.
    logic                  valid_q,    valid_d;
    logic [ADDR_W-1:0]     ret_addr_q, ret_addr_d;
    logic [BIT_LENGTH-1:0] out0_q,     out0_d;
    logic [BIT_LENGTH-1:0] out1_q,     out1_d;
    logic [BIT_LENGTH-1:0] out2_q,     out2_d;
    logic                  enable_q,   enable_d;
    logic                  done_q,     done_d;
    // Line buffers: index 0 is the entry point, index IMG_W-1 is the head.
    logic [BIT_LENGTH-1:0] chain0_q [IMG_W];
    logic [BIT_LENGTH-1:0] chain0_d [IMG_W];
    logic [BIT_LENGTH-1:0] chain1_q [IMG_W];
    logic [BIT_LENGTH-1:0] chain1_d [IMG_W];

    always_comb begin
        state_d    = state_q;
        rd_en_d    = rd_en_q;
        addr_d     = addr_q;
        valid_d    = rd_en_q;
        ret_addr_d = addr_q;
        out0_d     = out0_q;
        out1_d     = out1_q;
        out2_d     = out2_q;
        done_d     = done_q;
        // Only returned rows 2..IMG_H-1 form complete columns.
        enable_d   = valid_q && (ret_addr_q >= c_stream_first);
        for (int i = 0; i < IMG_W; i++) begin
            chain0_d[i] = chain0_q[i];
            chain1_d[i] = chain1_q[i];
        end

        if (valid_q) begin
            out2_d      = mem_rd_data;
            out1_d      = chain1_q[IMG_W-1];
            out0_d      = chain0_q[IMG_W-1];
            for (int i = IMG_W - 1; i > 0; i--) begin
                chain0_d[i] = chain0_q[i-1];
                chain1_d[i] = chain1_q[i-1];
            end
            chain0_d[0] = chain1_q[IMG_W-1];
            chain1_d[0] = mem_rd_data;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_PRIME;
                    rd_en_d = 1'b1;
                    addr_d  = '0;
                    done_d  = 1'b0;
                end
            end
            S_PRIME: begin
                addr_d = addr_q + c_addr_one;
                if (addr_q == c_prime_last) begin
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                if (rd_en_q) begin
                    if (addr_q == c_last_addr) begin
                        rd_en_d = 1'b0;
                    end else begin
                        addr_d = addr_q + c_addr_one;
                    end
                end
                // Returns are gap-free, so the first cycle with a column on
                // display but no data returning marks the end of the frame.
                if (enable_q && !valid_q) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            rd_en_q    <= 1'b0;
            addr_q     <= '0;
            valid_q    <= 1'b0;
            ret_addr_q <= '0;
            out0_q     <= '0;
            out1_q     <= '0;
            out2_q     <= '0;
            enable_q   <= 1'b0;
            done_q     <= 1'b0;
            for (int i = 0; i < IMG_W; i++) begin
                chain0_q[i] <= '0;
                chain1_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            rd_en_q    <= rd_en_d;
            addr_q     <= addr_d;
            valid_q    <= valid_d;
            ret_addr_q <= ret_addr_d;
            out0_q     <= out0_d;
            out1_q     <= out1_d;
            out2_q     <= out2_d;
            enable_q   <= enable_d;
            done_q     <= done_d;
            for (int i = 0; i < IMG_W; i++) begin
                chain0_q[i] <= chain0_d[i];
                chain1_q[i] <= chain1_d[i];
            end
        end
    end

    assign mem_rd_en  = rd_en_q;
    assign mem_addr   = addr_q;
    assign pixel_out0 = out0_q;
    assign pixel_out1 = out1_q;
    assign pixel_out2 = out2_q;
    assign enable     = enable_q;
    assign done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_sobel_col_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sobel_col_feeder
//  Description : Self-checking bench for sobel_col_feeder. A 4x4 and a 16x16
//                instance each read from their own SRAM model; a raster image
//                model supplies every expected column and frame timing.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sobel_col_feeder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // 4x4 instance
    logic       rst4, start4, rd4, en4, done4;
    logic [7:0] addr4;
    logic [4:0] rdata4, p04, p14, p24;
    // 16x16 instance
    logic       rst16, start16, rd16, en16, done16;
    logic [7:0] addr16;
    logic [4:0] rdata16, p016, p116, p216;

    logic [4:0] mem4  [256];
    logic [4:0] mem16 [256];

    sobel_col_feeder #(.BIT_LENGTH(5), .IMG_W(4), .IMG_H(4), .ADDR_W(8)) dut4 (
        .clk(clk), .reset(rst4), .start(start4),
        .mem_rd_en(rd4), .mem_addr(addr4), .mem_rd_data(rdata4),
        .pixel_out0(p04), .pixel_out1(p14), .pixel_out2(p24),
        .enable(en4), .done(done4)
    );

    sobel_col_feeder #(.BIT_LENGTH(5), .IMG_W(16), .IMG_H(16), .ADDR_W(8)) dut16 (
        .clk(clk), .reset(rst16), .start(start16),
        .mem_rd_en(rd16), .mem_addr(addr16), .mem_rd_data(rdata16),
        .pixel_out0(p016), .pixel_out1(p116), .pixel_out2(p216),
        .enable(en16), .done(done16)
    );

    // Single-port SRAM models: data valid the cycle after the strobe.
    always @(posedge clk) begin
        if (rd4)  rdata4  <= mem4[addr4];
        if (rd16) rdata16 <= mem16[addr16];
    end

    // Observation mux so one frame routine serves both instances.
    logic       sel;
    logic       o_rd, o_en, o_done;
    logic [7:0] o_addr;
    logic [4:0] o_p0, o_p1, o_p2;
    assign o_rd   = sel ? rd16   : rd4;
    assign o_en   = sel ? en16   : en4;
    assign o_done = sel ? done16 : done4;
    assign o_addr = sel ? addr16 : addr4;
    assign o_p0   = sel ? p016   : p04;
    assign o_p1   = sel ? p116   : p14;
    assign o_p2   = sel ? p216   : p24;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] pix(input bit use16, input int r, input int c);
        return use16 ? mem16[r*16 + c] : mem4[r*4 + c];
    endfunction

    task automatic drive_start(input bit use16, input logic v);
        if (use16) start16 = v;
        else       start4  = v;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rd_en"},  o_rd,   0);
        check({tag, "_addr"},   o_addr, 0);
        check({tag, "_enable"}, o_en,   0);
        check({tag, "_done"},   o_done, 0);
        check({tag, "_out0"},   o_p0,   0);
        check({tag, "_out1"},   o_p1,   0);
        check({tag, "_out2"},   o_p2,   0);
    endtask

    // One frame. Cycle 0 is the cycle in which start is high; the routine
    // returns at the negedge of cycle N+3 (first done cycle) so a following
    // call places its start exactly one cycle after done rose.
    // abort_at > 0 asserts reset on the 4x4 instance mid-cycle abort_at.
    task automatic run_frame(input bit use16, input int abort_at,
                             input int ign0, input int ign1);
        int w, h, n, first_en, last_en, run, idx;
        w = use16 ? 16 : 4;
        h = w;
        n = w * h;
        first_en = 2*w + 3;
        last_en  = n + 2;
        run = 0;
        sel = use16;
        @(negedge clk);
        drive_start(use16, 1'b1);
        for (int k = 1; k <= n + 3; k++) begin
            @(negedge clk);
            if (k == abort_at) begin
                rst4 = 1'b1;
                drive_start(use16, 1'b0);
                #1;
                check_idle_outputs("abort");
                return;
            end
            check("rd_en", o_rd, (k >= 1 && k <= n));
            if (k >= 1 && k <= n) check("addr", o_addr, k - 1);
            check("enable", o_en, (k >= first_en && k <= last_en));
            if (o_en) run++;
            if (k >= first_en && k <= last_en) begin
                idx = k - first_en;
                check("out0", o_p0, pix(use16, 2 + idx / w - 2, idx % w));
                check("out1", o_p1, pix(use16, 2 + idx / w - 1, idx % w));
                check("out2", o_p2, pix(use16, 2 + idx / w,     idx % w));
            end
            check("done", o_done, (k >= n + 3));
            drive_start(use16, (k == ign0 || k == ign1));
        end
        check("enable_run_len", run, w * (h - 2));
    endtask

    initial begin
        int g0, g1;
        rst4 = 1'b1; rst16 = 1'b1; start4 = 1'b0; start16 = 1'b0; sel = 1'b0;
        for (int a = 0; a < 256; a++) begin
            mem4[a]  = '0;
            mem16[a] = '0;
        end
        repeat (3) @(negedge clk);
        sel = 1'b0; #1; check_idle_outputs("reset4");
        sel = 1'b1; #1; check_idle_outputs("reset16");
        @(negedge clk);
        rst4 = 1'b0; rst16 = 1'b0;
        repeat (2) @(negedge clk);

        // Basic frame: SRAM[a] = a.
        for (int a = 0; a < 16; a++) mem4[a] = 5'(a);
        run_frame(0, -1, -1, -1);
        // Restart from DONE, one cycle after done rose.
        run_frame(0, -1, -1, -1);
        // Starts during PRIME and STREAM are ignored.
        run_frame(0, -1, 5, 12);

        // Reset in STREAM, then a clean repeat of the basic frame.
        run_frame(0, 13, -1, -1);
        repeat (2) @(negedge clk);
        sel = 1'b0; check_idle_outputs("in_reset");
        rst4 = 1'b0;
        repeat (2) @(negedge clk);
        run_frame(0, -1, -1, -1);

        // Extremes: all 31 except row 1 all zero.
        for (int a = 0; a < 16; a++) mem4[a] = (a / 4 == 1) ? 5'd0 : 5'd31;
        run_frame(0, -1, -1, -1);

        // Random 4x4 image.
        for (int a = 0; a < 16; a++) mem4[a] = 5'($urandom_range(0, 31));
        run_frame(0, -1, -1, -1);

        // Random 16x16 image with random ignored start pulses.
        for (int a = 0; a < 256; a++) mem16[a] = 5'($urandom_range(0, 31));
        g0 = $urandom_range(1, 33);
        g1 = $urandom_range(34, 258);
        run_frame(1, -1, g0, g1);

        // Second random 16x16 frame straight from DONE.
        for (int a = 0; a < 256; a++) mem16[a] = 5'($urandom);
        run_frame(1, -1, -1, -1);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Extremes spot check on the first enabled column of the 4x4 instance.
    int ext_seen = 0;
    always @(negedge clk) begin
        if (!rst4 && en4 && mem4[0] == 5'd31 && mem4[4] == 5'd0 && ext_seen == 0) begin
            ext_seen = 1;
            check("extreme_first_col", {p04, p14, p24}, {5'd31, 5'd0, 5'd31});
        end
    end

endmodule
`default_nettype wire
